// File: rtl/decode_if.sv
// Handshake and result bundle between fetch, the RV32I decode stage and execute.
// The stage uses the slave modport; the fetch/execute side uses master.
interface decode_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      instr_i;
    logic [XLEN-1:0]  pc_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [XLEN-1:0]  pc_o;
    logic [4:0]       rs1_o;
    logic [4:0]       rs2_o;
    logic [4:0]       rd_o;
    logic [6:0]       op_o;
    logic [2:0]       funct3_o;
    logic [9:0]       alu_op_sel_o;
    logic [XLEN-1:0]  imm_o;
    logic [6:0]       type_o;
    logic [CNT_W-1:0] decoded_cnt_o;
    logic [CNT_W-1:0] illegal_cnt_o;

    modport slave (
        input  flush_i, in_valid_i, instr_i, pc_i, out_ready_i,
        output in_ready_o, out_valid_o, pc_o, rs1_o, rs2_o, rd_o, op_o,
               funct3_o, alu_op_sel_o, imm_o, type_o, decoded_cnt_o, illegal_cnt_o
    );

    modport master (
        output flush_i, in_valid_i, instr_i, pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, pc_o, rs1_o, rs2_o, rd_o, op_o,
               funct3_o, alu_op_sel_o, imm_o, type_o, decoded_cnt_o, illegal_cnt_o
    );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: classifies instructions, extracts fields and immediates,
// and buffers up to two results (output + optional skid register) with flush and event counters.
module decode_stage #(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic     clk_i,
    input  logic     rst_i,
    decode_if.slave  bus
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [6:0]      op;
        logic [2:0]      funct3;
        logic [9:0]      alu;
        logic [XLEN-1:0] imm;
        logic [6:0]      typ;
    } dec_t;

    dec_t             dec, out_reg, skid_reg;
    logic             out_valid_reg, out_valid_next;
    logic             skid_valid_reg, skid_valid_next;
    logic             load_out, load_out_from_skid, load_skid;
    logic             in_ready, accept, drain;
    logic [CNT_W-1:0] decoded_cnt_reg, illegal_cnt_reg;
    logic [31:0]      instr, imm32;
    logic [6:0]       opc, funct7, typ;
    logic [2:0]       funct3;

    assign instr  = bus.instr_i;
    assign opc    = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // One-hot class {illegal,j,u,b,s,i,r}; the full 7-bit compare also enforces instr[1:0]=11.
    always_comb begin
        typ = 7'b1000000;
        case (opc)
            7'b0110011:                                     typ = 7'b0000001;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: typ = 7'b0000010;
            7'b0100011:                                     typ = 7'b0000100;
            7'b1100011:                                     typ = 7'b0001000;
            7'b0110111, 7'b0010111:                         typ = 7'b0010000;
            7'b1101111:                                     typ = 7'b0100000;
            default:                                        typ = 7'b1000000;
        endcase
    end

    always_comb begin
        dec     = '0;
        imm32   = '0;
        dec.pc  = bus.pc_i;
        dec.op  = opc;
        dec.typ = typ;
        if (!typ[6]) begin
            dec.rd     = (typ[2] | typ[3]) ? 5'd0 : instr[11:7];
            dec.rs1    = (typ[4] | typ[5]) ? 5'd0 : instr[19:15];
            dec.rs2    = (typ[0] | typ[2] | typ[3]) ? instr[24:20] : 5'd0;
            dec.funct3 = (typ[4] | typ[5]) ? 3'd0 : funct3;
        end
        if (typ[0]) begin
            dec.alu = {funct7, funct3};
        end else if (typ[1] && opc == 7'b0010011) begin
            // Only shifts carry funct7 (SRLI/SRAI distinction) into the ALU selector.
            dec.alu = (funct3 == 3'b001 || funct3 == 3'b101) ? {funct7, funct3} : {7'd0, funct3};
        end
        if (typ[1])      imm32 = {{20{instr[31]}}, instr[31:20]};
        else if (typ[2]) imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        else if (typ[3]) imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        else if (typ[4]) imm32 = {instr[31:12], 12'd0};
        else if (typ[5]) imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        dec.imm        = {XLEN{imm32[31]}};
        dec.imm[31:0]  = imm32;
    end

    assign accept = bus.in_valid_i & in_ready;
    assign drain  = out_valid_reg & bus.out_ready_i;

    // Occupancy control: skid contents always leave before newer input reaches the output.
    always_comb begin
        out_valid_next     = out_valid_reg;
        skid_valid_next    = skid_valid_reg;
        load_out           = 1'b0;
        load_out_from_skid = 1'b0;
        load_skid          = 1'b0;
        if (bus.flush_i) begin
            out_valid_next  = 1'b0;
            skid_valid_next = 1'b0;
        end else if (!out_valid_reg || drain) begin
            if (skid_valid_reg) begin
                load_out_from_skid = 1'b1;
                out_valid_next     = 1'b1;
                load_skid          = accept;
                skid_valid_next    = accept;
            end else begin
                load_out       = accept;
                out_valid_next = accept;
            end
        end else if (accept) begin
            load_skid       = 1'b1;
            skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_reg         <= '0;
            skid_reg        <= '0;
            out_valid_reg   <= 1'b0;
            skid_valid_reg  <= 1'b0;
            decoded_cnt_reg <= '0;
            illegal_cnt_reg <= '0;
        end else begin
            out_valid_reg  <= out_valid_next;
            skid_valid_reg <= skid_valid_next;
            if (load_out_from_skid) out_reg  <= skid_reg;
            else if (load_out)      out_reg  <= dec;
            if (load_skid)          skid_reg <= dec;
            if (accept && !bus.flush_i) begin
                decoded_cnt_reg <= decoded_cnt_reg + 1'b1;
                if (typ[6]) illegal_cnt_reg <= illegal_cnt_reg + 1'b1;
            end
        end
    end

    generate
        if (SKID_EN) begin : g_skid
            logic ready_reg;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) ready_reg <= 1'b1;
                else       ready_reg <= !skid_valid_next;
            end
            assign in_ready = ready_reg;
        end else begin : g_no_skid
            assign in_ready = !out_valid_reg | bus.out_ready_i;
        end
    endgenerate

    assign bus.in_ready_o    = in_ready;
    assign bus.out_valid_o   = out_valid_reg;
    assign bus.pc_o          = out_reg.pc;
    assign bus.rs1_o         = out_reg.rs1;
    assign bus.rs2_o         = out_reg.rs2;
    assign bus.rd_o          = out_reg.rd;
    assign bus.op_o          = out_reg.op;
    assign bus.funct3_o      = out_reg.funct3;
    assign bus.alu_op_sel_o  = out_reg.alu;
    assign bus.imm_o         = out_reg.imm;
    assign bus.type_o        = out_reg.typ;
    assign bus.decoded_cnt_o = decoded_cnt_reg;
    assign bus.illegal_cnt_o = illegal_cnt_reg;
endmodule
